// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control unit: sequences each instruction through
// FETCH/DECODE/EXEC/MEM/WB and drives the datapath and memory enables for each state.
// Unrecognised opcodes and memory handshakes that never complete both end in a
// sticky TRAP state, which only rst can leave.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   opcode, funct3,     instruction fields from the IR (stable from DECODE on)
//   funct7_5
//   zero                ALU zero flag, used by BEQ in EXEC
//   mem_ready           memory completes the current access this cycle
//   pcWrite, irWrite,   datapath enables
//   regWrite, aluSrc,
//   memRead, memWrite,
//   iord
//   aluControl          ALU operation code (zero-extended to ALU_CTRL_W)
//   illegal, memErr     sticky trap flags
//   state_dbg           current state encoding
module multicycle_control_fsm #(
  parameter int unsigned ALU_CTRL_W    = 4,
  parameter int unsigned MEM_TIMEOUT   = 15,
  parameter bit          ENABLE_BRANCH = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic                  funct7_5,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  pcWrite,
  output logic                  irWrite,
  output logic                  regWrite,
  output logic                  aluSrc,
  output logic                  memRead,
  output logic                  memWrite,
  output logic                  iord,
  output logic [ALU_CTRL_W-1:0] aluControl,
  output logic                  illegal,
  output logic                  memErr,
  output logic [2:0]            state_dbg
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned OP_W  = 4;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LW  = 7'b0000011;
  localparam logic [6:0] OPC_SW  = 7'b0100011;
  localparam logic [6:0] OPC_BEQ = 7'b1100011;

  localparam logic [OP_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [OP_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [OP_W-1:0] ALU_AND  = 4'd2;
  localparam logic [OP_W-1:0] ALU_OR   = 4'd3;
  localparam logic [OP_W-1:0] ALU_XOR  = 4'd4;
  localparam logic [OP_W-1:0] ALU_SLT  = 4'd5;
  localparam logic [OP_W-1:0] ALU_SLTU = 4'd6;
  localparam logic [OP_W-1:0] ALU_SLL  = 4'd7;
  localparam logic [OP_W-1:0] ALU_SRL  = 4'd8;
  localparam logic [OP_W-1:0] ALU_SRA  = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_R   = 3'd0,
    C_I   = 3'd1,
    C_LW  = 3'd2,
    C_SW  = 3'd3,
    C_BEQ = 3'd4
  } cls_t;

  state_t          state, state_next;
  cls_t            cls, cls_next;
  cls_t            op_cls;
  logic            op_ok;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic            illegal_next, mem_err_next;
  logic [OP_W-1:0] alu_fn;
  logic            wait_limit;

  assign state_dbg  = state;
  assign wait_limit = (cnt == CNT_W'(MEM_TIMEOUT));

  // Opcode to instruction class; branches are only legal when enabled
  always_comb begin : opcode_decode
    op_ok  = 1'b1;
    op_cls = C_R;
    case (opcode)
      OPC_R:   op_cls = C_R;
      OPC_I:   op_cls = C_I;
      OPC_LW:  op_cls = C_LW;
      OPC_SW:  op_cls = C_SW;
      OPC_BEQ: begin
        op_cls = C_BEQ;
        op_ok  = ENABLE_BRANCH;
      end
      default: op_ok = 1'b0;
    endcase
  end

  // R/I ALU function; for I-type funct7_5 only selects SRA vs SRL
  always_comb begin : alu_decode
    alu_fn = ALU_ADD;
    case (funct3)
      3'b000:  alu_fn = (funct7_5 && (cls == C_R)) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_fn = ALU_AND;
      3'b110:  alu_fn = ALU_OR;
      3'b100:  alu_fn = ALU_XOR;
      3'b010:  alu_fn = ALU_SLT;
      3'b011:  alu_fn = ALU_SLTU;
      3'b001:  alu_fn = ALU_SLL;
      default: alu_fn = funct7_5 ? ALU_SRA : ALU_SRL;
    endcase
  end

  // State register, latched class, timeout counter and sticky trap flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cls     <= C_R;
      cnt     <= '0;
      illegal <= 1'b0;
      memErr  <= 1'b0;
    end else begin
      state   <= state_next;
      cls     <= cls_next;
      cnt     <= cnt_next;
      illegal <= illegal_next;
      memErr  <= mem_err_next;
    end
  end

  // Next-state and per-state datapath enables
  always_comb begin : fsm_comb
    state_next   = state;
    cls_next     = cls;
    illegal_next = illegal;
    mem_err_next = memErr;
    pcWrite      = 1'b0;
    irWrite      = 1'b0;
    regWrite     = 1'b0;
    aluSrc       = 1'b0;
    memRead      = 1'b0;
    memWrite     = 1'b0;
    iord         = 1'b0;
    aluControl   = ALU_CTRL_W'(ALU_ADD);

    case (state)
      S_IDLE: state_next = S_FETCH;

      S_FETCH: begin
        memRead = 1'b1;
        if (mem_ready) begin
          irWrite    = 1'b1;
          pcWrite    = 1'b1;
          state_next = S_DECODE;
        end else if (wait_limit) begin
          state_next   = S_TRAP;
          mem_err_next = 1'b1;
        end
      end

      S_DECODE: begin
        if (op_ok) begin
          cls_next   = op_cls;
          state_next = S_EXEC;
        end else begin
          illegal_next = 1'b1;
          state_next   = S_TRAP;
        end
      end

      S_EXEC: begin
        case (cls)
          C_R: begin
            aluControl = ALU_CTRL_W'(alu_fn);
            state_next = S_WB;
          end
          C_I: begin
            aluSrc     = 1'b1;
            aluControl = ALU_CTRL_W'(alu_fn);
            state_next = S_WB;
          end
          C_LW, C_SW: begin
            aluSrc     = 1'b1;
            state_next = S_MEM;
          end
          C_BEQ: begin
            aluControl = ALU_CTRL_W'(ALU_SUB);
            pcWrite    = zero;
            state_next = S_FETCH;
          end
          default: begin
            illegal_next = 1'b1;
            state_next   = S_TRAP;
          end
        endcase
      end

      S_MEM: begin
        iord   = 1'b1;
        aluSrc = 1'b1;
        if (cls == C_SW) memWrite = 1'b1;
        else             memRead  = 1'b1;
        if (mem_ready) begin
          state_next = (cls == C_SW) ? S_FETCH : S_WB;
        end else if (wait_limit) begin
          state_next   = S_TRAP;
          mem_err_next = 1'b1;
        end
      end

      S_WB: begin
        regWrite   = 1'b1;
        state_next = S_FETCH;
      end

      S_TRAP: state_next = S_TRAP;

      default: state_next = S_IDLE;
    endcase

    // Counter measures consecutive stalled cycles within one state visit
    if (state_next != state) begin
      cnt_next = '0;
    end else if (((state == S_FETCH) || (state == S_MEM)) && !mem_ready) begin
      cnt_next = cnt + CNT_W'(1);
    end else begin
      cnt_next = cnt;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: state sequencing, ALU decode,
// memory wait/timeout, branches, illegal-opcode trap and async reset.
module tb_multicycle_control_fsm;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LW  = 7'b0000011;
  localparam logic [6:0] OPC_SW  = 7'b0100011;
  localparam logic [6:0] OPC_BEQ = 7'b1100011;
  localparam logic [6:0] OPC_BAD = 7'b1111111;

  // Enable vector order: {pcWrite, irWrite, regWrite, aluSrc, memRead, memWrite, iord}
  localparam logic [6:0] O_NONE  = 7'b0000000;
  localparam logic [6:0] O_FHS   = 7'b1100100;
  localparam logic [6:0] O_FWAIT = 7'b0000100;
  localparam logic [6:0] O_EIMM  = 7'b0001000;
  localparam logic [6:0] O_MLW   = 7'b0001101;
  localparam logic [6:0] O_MSW   = 7'b0001011;
  localparam logic [6:0] O_WB    = 7'b0010000;
  localparam logic [6:0] O_BEQT  = 7'b1000000;

  logic       clk, rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5, zero, mem_ready;
  logic       pcWrite, irWrite, regWrite, aluSrc, memRead, memWrite, iord;
  logic [3:0] aluControl;
  logic       illegal, memErr;
  logic [2:0] state_dbg;
  logic       nb_pcWrite, nb_irWrite, nb_regWrite, nb_aluSrc, nb_memRead, nb_memWrite, nb_iord;
  logic [3:0] nb_aluControl;
  logic       nb_illegal, nb_memErr;
  logic [2:0] nb_state_dbg;
  logic [6:0] outs;

  int errors = 0;
  int checks = 0;

  assign outs = {pcWrite, irWrite, regWrite, aluSrc, memRead, memWrite, iord};

  multicycle_control_fsm u_dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem_ready(mem_ready), .pcWrite(pcWrite), .irWrite(irWrite),
    .regWrite(regWrite), .aluSrc(aluSrc), .memRead(memRead), .memWrite(memWrite),
    .iord(iord), .aluControl(aluControl), .illegal(illegal), .memErr(memErr),
    .state_dbg(state_dbg)
  );

  multicycle_control_fsm #(.ENABLE_BRANCH(1'b0)) u_nb (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem_ready(mem_ready), .pcWrite(nb_pcWrite), .irWrite(nb_irWrite),
    .regWrite(nb_regWrite), .aluSrc(nb_aluSrc), .memRead(nb_memRead),
    .memWrite(nb_memWrite), .iord(nb_iord), .aluControl(nb_aluControl),
    .illegal(nb_illegal), .memErr(nb_memErr), .state_dbg(nb_state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks state, enable vector and ALU code for the current cycle
  task automatic cyc(input string tag, input logic [2:0] st, input logic [6:0] o,
                     input logic [3:0] alu);
    #1;
    chk({tag, ".state"}, 32'(state_dbg), 32'(st));
    chk({tag, ".outs"}, 32'(outs), 32'(o));
    chk({tag, ".alu"}, 32'(aluControl), 32'(alu));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic [3:0] alu;
  } vec_t;

  vec_t tbl[13] = '{
    '{OPC_R, 3'b000, 1'b1, 4'd1}, '{OPC_R, 3'b000, 1'b0, 4'd0},
    '{OPC_R, 3'b101, 1'b1, 4'd9}, '{OPC_R, 3'b101, 1'b0, 4'd8},
    '{OPC_R, 3'b111, 1'b0, 4'd2}, '{OPC_R, 3'b110, 1'b0, 4'd3},
    '{OPC_R, 3'b100, 1'b0, 4'd4}, '{OPC_R, 3'b010, 1'b0, 4'd5},
    '{OPC_R, 3'b011, 1'b0, 4'd6}, '{OPC_R, 3'b001, 1'b0, 4'd7},
    '{OPC_I, 3'b000, 1'b1, 4'd0}, '{OPC_I, 3'b101, 1'b1, 4'd9},
    '{OPC_I, 3'b010, 1'b1, 4'd5}
  };

  initial begin
    rst = 1'b1; opcode = OPC_R; funct3 = 3'b000; funct7_5 = 1'b1;
    zero = 1'b0; mem_ready = 1'b1;
    step(); step();
    cyc("reset", 3'd0, O_NONE, 4'd0);
    chk("reset.illegal", 32'(illegal), 32'd0);
    chk("reset.memErr", 32'(memErr), 32'd0);
    rst = 1'b0;
    cyc("idle", 3'd0, O_NONE, 4'd0);
    step();

    // R/I instructions: FETCH, DECODE, EXEC, WB, back to FETCH
    for (int i = 0; i < 13; i++) begin
      opcode = tbl[i].op; funct3 = tbl[i].f3; funct7_5 = tbl[i].f7;
      cyc("ri.fetch", 3'd1, O_FHS, 4'd0);
      step(); cyc("ri.decode", 3'd2, O_NONE, 4'd0);
      step(); cyc("ri.exec", 3'd3, (tbl[i].op == OPC_I) ? O_EIMM : O_NONE, tbl[i].alu);
      step(); cyc("ri.wb", 3'd5, O_WB, 4'd0);
      step();
    end

    // LW with three stalled MEM cycles
    opcode = OPC_LW; funct3 = 3'b010; funct7_5 = 1'b0;
    cyc("lw.fetch", 3'd1, O_FHS, 4'd0);
    step(); cyc("lw.decode", 3'd2, O_NONE, 4'd0);
    step(); cyc("lw.exec", 3'd3, O_EIMM, 4'd0);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); cyc("lw.memwait", 3'd4, O_MLW, 4'd0);
    end
    step(); mem_ready = 1'b1;
    cyc("lw.memdone", 3'd4, O_MLW, 4'd0);
    step(); cyc("lw.wb", 3'd5, O_WB, 4'd0);
    chk("lw.memErr", 32'(memErr), 32'd0);
    step();

    // SW with immediate handshake: 4 cycles
    opcode = OPC_SW;
    cyc("sw.fetch", 3'd1, O_FHS, 4'd0);
    step(); cyc("sw.decode", 3'd2, O_NONE, 4'd0);
    step(); cyc("sw.exec", 3'd3, O_EIMM, 4'd0);
    step(); cyc("sw.mem", 3'd4, O_MSW, 4'd0);
    step(); cyc("sw.next", 3'd1, O_FHS, 4'd0);

    // BEQ taken then not taken; branch-less instance traps
    opcode = OPC_BEQ; zero = 1'b1;
    step(); cyc("beq1.decode", 3'd2, O_NONE, 4'd0);
    step(); cyc("beq1.exec", 3'd3, O_BEQT, 4'd1);
    chk("nb.state", 32'(nb_state_dbg), 32'd6);
    chk("nb.illegal", 32'(nb_illegal), 32'd1);
    step(); cyc("beq1.next", 3'd1, O_FHS, 4'd0);
    zero = 1'b0;
    step(); cyc("beq2.decode", 3'd2, O_NONE, 4'd0);
    step(); cyc("beq2.exec", 3'd3, O_NONE, 4'd1);
    step();

    // FETCH stall: handshake arrives in the cycle the limit is reached
    opcode = OPC_R; funct3 = 3'b000; funct7_5 = 1'b0; mem_ready = 1'b0;
    cyc("to1.fetch", 3'd1, O_FWAIT, 4'd0);
    repeat (15) step();
    cyc("to1.limit", 3'd1, O_FWAIT, 4'd0);
    mem_ready = 1'b1;
    cyc("to1.rescue", 3'd1, O_FHS, 4'd0);
    step(); cyc("to1.decode", 3'd2, O_NONE, 4'd0);
    chk("to1.memErr", 32'(memErr), 32'd0);
    step(); step(); step();
    cyc("to2.fetch", 3'd1, O_FHS, 4'd0);

    // FETCH stall that never completes
    mem_ready = 1'b0;
    repeat (15) step();
    cyc("to2.limit", 3'd1, O_FWAIT, 4'd0);
    chk("to2.memErr_pre", 32'(memErr), 32'd0);
    step(); cyc("to2.trap", 3'd6, O_NONE, 4'd0);
    chk("to2.memErr", 32'(memErr), 32'd1);
    chk("to2.illegal", 32'(illegal), 32'd0);

    rst = 1'b1; #1;
    chk("to2.rst_memErr", 32'(memErr), 32'd0);
    step(); rst = 1'b0; mem_ready = 1'b1;

    // SW interrupted by reset in MEM
    opcode = OPC_SW;
    step(); cyc("swr.fetch", 3'd1, O_FHS, 4'd0);
    step(); step(); mem_ready = 1'b0;
    step(); cyc("swr.mem", 3'd4, O_MSW, 4'd0);
    rst = 1'b1; #1;
    chk("swr.async_memWrite", 32'(memWrite), 32'd0);
    chk("swr.async_state", 32'(state_dbg), 32'd0);
    step(); rst = 1'b0; mem_ready = 1'b1;
    cyc("swr.idle", 3'd0, O_NONE, 4'd0);
    step(); cyc("swr.fetch2", 3'd1, O_FHS, 4'd0);

    // Illegal opcode traps after DECODE and stays quiet
    opcode = OPC_BAD;
    step(); cyc("ill.decode", 3'd2, O_NONE, 4'd0);
    step();
    chk("ill.illegal", 32'(illegal), 32'd1);
    for (int i = 0; i < 20; i++) begin
      cyc("ill.trap", 3'd6, O_NONE, 4'd0);
      step();
    end
    rst = 1'b1; #1;
    chk("ill.rst_illegal", 32'(illegal), 32'd0);
    chk("ill.rst_state", 32'(state_dbg), 32'd0);
    step(); rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
